// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: buffers signed mono samples in a small FIFO and
// serializes each one to a WM8731 DAC as I2S on both channels.
//
// Ports:
//   i_clk, i_rst_n     system clock, async active-low reset
//   i_sample, i_valid  sample input, pushed when i_valid && o_ready
//   o_ready            FIFO not full
//   i_AUD_BCLK         codec bit clock (async, codec is master)
//   i_AUD_DACLRCK      codec frame clock, low = left, high = right
//   o_AUD_DACDAT       registered serial data to the codec
//   o_underflow        1-cycle pulse: frame started with an empty FIFO
//   o_fifo_level       FIFO occupancy
module audio_dac_serializer #(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [DATA_W-1:0]           i_sample,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic                        i_AUD_BCLK,
    input  logic                        i_AUD_DACLRCK,
    output logic                        o_AUD_DACDAT,
    output logic                        o_underflow,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        SHIFT,
        PAD
    } state_t;

    // Codec clock synchronizers and edge strobes
    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic                   bclk_prev;
    logic                   lrck_prev;
    logic                   bclk_fall;
    logic                   lrck_fall;
    logic                   lrck_rise;
    logic                   bclk_s;
    logic                   lrck_s;

    assign bclk_s = bclk_sync[SYNC_STAGES-1];
    assign lrck_s = lrck_sync[SYNC_STAGES-1];

    // Strobes are registered so the pin-to-DACDAT delay is
    // SYNC_STAGES+2 cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            bclk_prev <= 1'b0;
            lrck_prev <= 1'b0;
            bclk_fall <= 1'b0;
            lrck_fall <= 1'b0;
            lrck_rise <= 1'b0;
        end else begin
            bclk_sync <= (bclk_sync << 1) | SYNC_STAGES'(i_AUD_BCLK);
            lrck_sync <= (lrck_sync << 1) | SYNC_STAGES'(i_AUD_DACLRCK);
            bclk_prev <= bclk_s;
            lrck_prev <= lrck_s;
            bclk_fall <= bclk_prev & ~bclk_s;
            lrck_fall <= lrck_prev & ~lrck_s;
            lrck_rise <= ~lrck_prev & lrck_s;
        end
    end

    // Sample FIFO
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       level;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    assign full  = (level == (AW+1)'(FIFO_DEPTH));
    assign empty = (level == '0);
    assign push  = i_valid & ~full;
    // A push into an empty FIFO cannot be popped in the same cycle,
    // since emptiness is judged from registered state.
    assign pop   = lrck_fall & ~empty;
    assign head  = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_sample;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + (AW+1)'(1);
            end else if (pop && !push) begin
                level <= level - (AW+1)'(1);
            end
        end
    end

    // Held sample: repeated on underflow and reused for the right channel
    logic [DATA_W-1:0] held_sample;
    logic [DATA_W-1:0] load_val;
    logic              underflow_q;

    assign load_val = pop ? head : held_sample;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            held_sample <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (pop) begin
                held_sample <= head;
            end
            underflow_q <= lrck_fall & empty;
        end
    end

    // Serializer FSM
    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic [CW-1:0]     bit_cnt;
    logic [CW-1:0]     cnt_nxt;
    logic              dat;
    logic              dat_nxt;
    logic              lrck_edge;

    assign lrck_edge = lrck_fall | lrck_rise;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            dat     <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= cnt_nxt;
            dat     <= dat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = bit_cnt;
        dat_nxt   = dat;
        unique case (state)
            IDLE: begin
                dat_nxt = 1'b0;
                if (lrck_fall) begin
                    shreg_nxt = load_val;
                    cnt_nxt   = '0;
                    state_nxt = DELAY;
                end
            end
            DELAY, SHIFT: begin
                if (lrck_edge) begin
                    shreg_nxt = load_val;
                    cnt_nxt   = '0;
                    state_nxt = DELAY;
                end else if (bclk_fall) begin
                    // bit_cnt counts bits already driven; DELAY
                    // enters with 0 so its fall drives the MSB.
                    if (bit_cnt == CW'(DATA_W)) begin
                        dat_nxt   = 1'b0;
                        state_nxt = PAD;
                    end else begin
                        dat_nxt   = shreg[DATA_W-1];
                        shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
                        cnt_nxt   = bit_cnt + CW'(1);
                        state_nxt = SHIFT;
                    end
                end
            end
            PAD: begin
                dat_nxt = 1'b0;
                if (lrck_edge) begin
                    shreg_nxt = load_val;
                    cnt_nxt   = '0;
                    state_nxt = DELAY;
                end
            end
        endcase
    end

    assign o_ready      = ~full;
    assign o_fifo_level = level;
    assign o_AUD_DACDAT = dat;
    assign o_underflow  = underflow_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb_audio_dac_serializer: drives the DAC serializer as the codec master
// and receives the I2S stream, checking it against a sample-level model.
module tb_audio_dac_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sample = '0;
    logic        valid = 1'b0;
    logic        ready;
    logic        bclk = 1'b1;
    logic        lrck = 1'b1;
    logic        dat;
    logic        uf;
    logic [2:0]  level;

    int n_cmp = 0;
    int n_bad = 0;

    audio_dac_serializer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_sample      (sample),
        .i_valid       (valid),
        .o_ready       (ready),
        .i_AUD_BCLK    (bclk),
        .i_AUD_DACLRCK (lrck),
        .o_AUD_DACDAT  (dat),
        .o_underflow   (uf),
        .o_fifo_level  (level)
    );

    always #5 clk = ~clk;

    // Model state: sample queue, held word, receiver position
    logic [15:0] q[$];
    logic [15:0] held = '0;
    logic [15:0] word = '0;
    logic        active = 1'b0;
    logic        lrck_last = 1'b1;
    int          rise_idx = 0;
    int          exp_uf = 0;
    int          uf_seen = 0;
    logic [15:0] rx_l = '0;
    logic [15:0] rx_r = '0;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Frame-level model: sample choice happens on the LRCK fall
    always @(negedge bclk) begin
        if (lrck !== lrck_last) begin
            lrck_last = lrck;
            rise_idx = 0;
            if (!lrck) begin
                if (q.size() > 0) held = q.pop_front();
                else exp_uf++;
                active = 1'b1;
            end
            word = held;
        end
    end

    // Codec receiver: word bits occupy rises 2..17 of each channel
    always @(posedge bclk) begin
        logic eb;
        rise_idx++;
        eb = 1'b0;
        if (active && rise_idx >= 2 && rise_idx <= 17)
            eb = word[17 - rise_idx];
        check("dacdat", dat, eb);
        if (active && rise_idx >= 2 && rise_idx <= 17) begin
            if (lrck) rx_r = {rx_r[14:0], dat};
            else rx_l = {rx_l[14:0], dat};
        end
    end

    always @(negedge clk) begin
        if (uf === 1'b1) uf_seen++;
        check("ready_vs_full", ready, level != 3'd4);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic period(input logic lv);
        lrck = lv;
        bclk = 1'b0;
        tick(8);
        bclk = 1'b1;
        tick(8);
    endtask

    task automatic frame();
        for (int i = 0; i < 32; i++) period(1'b0);
        for (int i = 0; i < 32; i++) period(1'b1);
    endtask

    task automatic push(input logic [15:0] x);
        sample = x;
        valid = 1'b1;
        tick(1);
        valid = 1'b0;
        if (q.size() < 4) q.push_back(x);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        held = '0;
        active = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected done");
        $fatal(1);
    end

    initial begin
        tick(3);
        check("rst_ready", ready, 1);
        check("rst_dat", dat, 0);
        check("rst_uf", uf, 0);
        check("rst_level", level, 0);
        rst_n = 1'b1;
        tick(4);

        // One frame of A5C3
        push(16'hA5C3);
        check("t1_level_pre", level, 1);
        frame();
        check("t1_rx_l", rx_l, 16'hA5C3);
        check("t1_rx_r", rx_r, 16'hA5C3);
        check("t1_level_post", level, 0);

        // Underflow after reset, then 8000
        do_reset();
        uf_seen = 0;
        exp_uf = 0;
        for (int f = 0; f < 3; f++) frame();
        check("t2_uf_count", uf_seen, 3);
        check("t2_rx_l_zero", rx_l, 0);
        push(16'h8000);
        frame();
        check("t2_rx_l", rx_l, 16'h8000);
        check("t2_uf_count2", uf_seen, 3);

        // Fill to full with LRCK high
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        push(16'h4444);
        check("t3_ready_full", ready, 0);
        check("t3_level_full", level, 4);
        push(16'h5555);
        check("t3_level_5th", level, 4);
        frame();
        check("t3_rx_l", rx_l, 16'h1111);
        check("t3_level_post", level, 3);
        check("t3_ready_post", ready, 1);

        // Full FIFO with i_valid held across the pop
        push(16'h6666);
        check("t4_level_full", level, 4);
        sample = 16'h7777;
        valid = 1'b1;
        lrck = 1'b0;
        bclk = 1'b0;
        tick(3);
        check("t4_level_at_strobe", level, 4);
        check("t4_ready_at_strobe", ready, 0);
        tick(1);
        check("t4_level_pop", level, 3);
        check("t4_ready_pop", ready, 1);
        tick(1);
        check("t4_level_push", level, 4);
        valid = 1'b0;
        q.push_back(16'h7777);
        tick(3);
        bclk = 1'b1;
        tick(8);
        for (int i = 1; i < 32; i++) period(1'b0);
        for (int i = 0; i < 32; i++) period(1'b1);
        check("t4_rx_l", rx_l, 16'h2222);

        // Drain, then push on the underflow cycle
        for (int f = 0; f < 4; f++) frame();
        check("t5_rx_l_drain", rx_l, 16'h7777);
        check("t5_level_empty", level, 0);
        lrck = 1'b0;
        bclk = 1'b0;
        tick(3);
        sample = 16'hBEEF;
        valid = 1'b1;
        tick(1);
        valid = 1'b0;
        check("t5_uf_pulse", uf, 1);
        check("t5_level_one", level, 1);
        q.push_back(16'hBEEF);
        tick(4);
        bclk = 1'b1;
        tick(8);
        for (int i = 1; i < 32; i++) period(1'b0);
        for (int i = 0; i < 32; i++) period(1'b1);
        check("t5_rx_repeat", rx_l, 16'h7777);
        check("t5_level_after", level, 1);
        frame();
        check("t5_rx_beef", rx_l, 16'hBEEF);

        // Reset mid-SHIFT on bit 7 of FFFF
        push(16'hFFFF);
        for (int i = 0; i < 9; i++) period(1'b0);
        lrck = 1'b0;
        bclk = 1'b0;
        tick(6);
        check("t6_bit7", dat, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_dat", dat, 0);
        check("t6_rst_level", level, 0);
        check("t6_rst_ready", ready, 1);
        q.delete();
        held = '0;
        active = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        bclk = 1'b1;
        tick(8);
        for (int i = 10; i < 32; i++) period(1'b0);
        for (int i = 0; i < 32; i++) period(1'b1);
        push(16'h1234);
        frame();
        check("t6_rx_l", rx_l, 16'h1234);
        check("t6_rx_r", rx_r, 16'h1234);
        check("uf_total", uf_seen, exp_uf);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
